// File: rtl/seq_array_mult.sv
// seq_array_mult: iterative WIDTH x WIDTH multiplier consuming DIGIT bits of b per cycle, signed/unsigned, valid/ready
module seq_array_mult #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, a_mag, b_mag;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d, product_q, product_d, sum;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH+DIGIT-1:0] pp;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
  assign a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign pp        = (WIDTH+DIGIT)'(a_q) * (WIDTH+DIGIT)'(b_q[DIGIT-1:0]);
  assign sum       = acc_q + (PW'(pp) << (int'(cnt_q) * DIGIT));
  // next state: accept magnitudes in IDLE, accumulate one digit row per RUN cycle, hold result in DONE
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a_mag;
        b_d     = b_mag;
        neg_d   = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = sum;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d   = DONE;
          product_d = neg_q ? -sum : sum;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_array_mult.sv
// tb_seq_array_mult: directed vector table plus handshake, reset and parameter-variant sequences
module tb_seq_array_mult;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [31:0] a, b;
  logic [63:0] product;
  logic        vvalid, vsm, r8, r16, ov8, ov16;
  logic [15:0] va, vb, p8;
  logic [31:0] p16;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  seq_array_mult dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .product(product));
  seq_array_mult #(.WIDTH(8), .DIGIT(1)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(vvalid), .in_ready(r8),
    .a(va[7:0]), .b(vb[7:0]), .signed_mode(vsm), .out_valid(ov8), .out_ready(1'b1), .product(p8));
  seq_array_mult #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(vvalid), .in_ready(r16),
    .a(va), .b(vb), .signed_mode(vsm), .out_valid(ov16), .out_ready(1'b1), .product(p16));
  typedef struct { logic [31:0] a, b; logic sm; logic [63:0] exp; } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_op(input logic [31:0] oa, ob, input logic sm, ordy, output logic [63:0] p, output int lat);
    @(negedge clk);
    a = oa; b = ob; signed_mode = sm; out_ready = ordy; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = ~oa; b = ~ob; signed_mode = ~sm; lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = product;
  endtask
  task automatic vop(input logic [15:0] xa, xb, input logic sm);
    logic [15:0] e8, g8v;
    logic [31:0] e16, g16v;
    int l8, l16;
    bit g8, g16;
    e8  = sm ? 16'(longint'($signed(xa[7:0])) * longint'($signed(xb[7:0]))) : 16'(longint'(xa[7:0]) * longint'(xb[7:0]));
    e16 = sm ? 32'(longint'($signed(xa)) * longint'($signed(xb))) : 32'(longint'(xa) * longint'(xb));
    @(negedge clk);
    va = xa; vb = xb; vsm = sm; vvalid = 1'b1;
    @(negedge clk);
    vvalid = 1'b0; va = ~xa; vb = ~xb; vsm = ~sm;
    g8 = 0; g16 = 0; l8 = -1; l16 = -1; g8v = '0; g16v = '0;
    for (int n = 0; n < 20; n++) begin
      if (!g8 && ov8) begin g8 = 1; l8 = n; g8v = p8; end
      if (!g16 && ov16) begin g16 = 1; l16 = n; g16v = p16; end
      if (g8 && g16) break;
      @(negedge clk);
    end
    chk($sformatf("w8 %h*%h sm%0d prod", xa[7:0], xb[7:0], sm), 64'(g8v), 64'(e8));
    chk("w8 latency", 64'(l8), 64'd8);
    chk($sformatf("w16 %h*%h sm%0d prod", xa, xb, sm), 64'(g16v), 64'(e16));
    chk("w16 latency", 64'(l16), 64'd1);
  endtask
  initial begin
    logic [63:0] p;
    int lat;
    tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[1]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFFFFFFFFF1};
    tbl[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    tbl[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[4]  = '{32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF80000000};
    tbl[5]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
    tbl[6]  = '{32'hFFFFFFFD, 32'd5,        1'b0, 64'h00000004FFFFFFF1};
    tbl[7]  = '{32'd0,        32'hFFFFFFFF, 1'b1, 64'h0};
    tbl[8]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    tbl[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
    tbl[10] = '{32'hFFFFFFFF, 32'd2,        1'b1, 64'hFFFFFFFFFFFFFFFE};
    tbl[11] = '{32'd1234,     32'd5678,     1'b1, 64'h00000000006AE9BC};
    in_valid = 0; out_ready = 1; a = '0; b = '0; signed_mode = 0;
    vvalid = 0; va = '0; vb = '0; vsm = 0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset product", product, 64'd0);
    chk("reset w16 product", 64'(p16), 64'd0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sm, 1'b1, p, lat);
      chk($sformatf("vec%0d product", i), p, tbl[i].exp);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid pulse", i), 64'(out_valid), 64'd0);
      chk($sformatf("vec%0d in_ready back", i), 64'(in_ready), 64'd1);
    end
    do_op(32'd1234, 32'd5678, 1'b0, 1'b0, p, lat);
    chk("bp product", p, 64'h6AE9BC);
    chk("bp latency", 64'(lat), 64'd8);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d product", k), product, 64'h6AE9BC);
      chk($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
      in_valid = (k == 3); a = 32'd3; b = 32'd3; signed_mode = 1'b0;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    chk("bp held product in idle", product, 64'h6AE9BC);
    @(negedge clk);
    chk("bp pulse not accepted", 64'(in_ready), 64'd1);
    a = 32'd7; b = 32'd9; signed_mode = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset product", product, 64'd0);
    rst_n = 1;
    do_op(32'd2, 32'd3, 1'b0, 1'b1, p, lat);
    chk("after reset product", p, 64'd6);
    chk("after reset latency", 64'(lat), 64'd8);
    vop(16'hFFFF, 16'hFFFF, 1'b0);
    vop(16'h8080, 16'h8080, 1'b1);
    vop(16'h8080, 16'h0101, 1'b1);
    vop(16'h0000, 16'hFFFF, 1'b1);
    vop(16'h7F7F, 16'h8080, 1'b0);
    for (int i = 0; i < 300; i++) vop(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
